ifu_prefetch: RTL and testbench
===============================

# ifu_prefetch

Decoupled instruction fetch unit for the ysyx core. It replaces the combinational DPI fetch with a valid/ready request/response memory port and an in-order prefetch buffer of parametrised depth. It accepts PC redirects from EXU and discards in-flight responses from the old stream. It sits between instruction memory (or the bus bridge) and the IDU.

## Interface
- `WIDTH`, 32: address width; instructions are always 32 bits
- `RESET_PC`, 32'h80000000: first fetch address after reset
- `DEPTH`, 4: prefetch buffer entries; a power of two, ≥2; also the cap on outstanding requests

- `clk`  in  1  clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  out  1  fetch request valid
- `req_ready`  in  1  memory accepts the request
- `req_addr`  out  WIDTH  fetch address, word aligned
- `rsp_valid`  in  1  response valid; in order; at least 1 cycle after acceptance; always accepted
- `rsp_data`  in  32  instruction word
- `rsp_err`  in  1  access fault for this response
- `inst_valid`  out  1  buffer head valid
- `inst_ready`  in  1  IDU consumes the head
- `inst`  out  32  head instruction
- `inst_pc`  out  WIDTH  head PC
- `inst_err`  out  1  head fault flag
- `redirect_valid`  in  1  flush and restart fetch
- `redirect_pc`  in  WIDTH  new fetch PC; bits [1:0] forced to 0

## Operation
- State:
  - fetch PC `fpc`
  - registered request (`req_valid`, `req_addr`)
  - FIFO count `cnt`
  - live outstanding `live`
  - to-drop outstanding `drop`
  - each counter is clog2(DEPTH)+1 bits
- Issue rule: a new request is loaded when no request is pending, or when the pending one handshakes this cycle, and `cnt + live + drop < DEPTH`, counted after this cycle's handshakes. The new request gets `req_addr=fpc`, and `fpc += 4` wraps modulo 2^WIDTH.
- Request stability: `req_valid`/`req_addr` hold unchanged until `req_ready`. Retraction is never allowed, including across a redirect.
- Request accepted: `live += 1`.
- Response handling:
  - If `drop > 0`, the response is discarded and `drop -= 1`.
  - Otherwise `{pc, rsp_data, rsp_err}` is pushed and `live -= 1`. The PC is tracked in an in-order PC queue with the same depth, or recomputed from the head PC.
- Pop: `inst_valid & inst_ready` removes the head.
- Redirect (highest priority), applied after this cycle's handshakes:
  - FIFO flushed; `cnt = 0`.
  - `drop = live + drop`, including any request accepted this cycle and excluding any response absorbed this cycle.
  - `live = 0`.
  - `fpc = {redirect_pc[WIDTH-1:2], 2'b00}`.
  - A pending unaccepted request stays asserted. When accepted it is counted into `drop`, because it is tagged stale.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle counts as delivered.
- Boundaries:
  - Full/credit: `cnt + live + drop == DEPTH` blocks issue, so a push into a full FIFO cannot occur.
  - Empty: `inst_valid=0`. Simultaneous push and pop keeps `cnt`.
  - `rsp_err`: stored with the entry; fetching continues sequentially.
  - A response with `live==drop==0` is a protocol error; assertion only.
- Reset values:
  - `req_valid=0`, `req_addr=RESET_PC`
  - `inst_valid=0`, `inst=0`, `inst_pc=0`, `inst_err=0`
  - `cnt=live=drop=0`, `fpc=RESET_PC`
  - A reset mid-operation abandons all in-flight transactions. The memory side is reset together with this block.

## Timing
- First `req_valid=1` with `req_addr=RESET_PC` in the first cycle after `rst` deasserts.
- Response at cycle t gives `inst_valid` at t+1 (FIFO registered, show-ahead head).
- Redirect at t with no pending request gives `req_valid` at t+1 with the new PC.
- With single-cycle memory, `req_ready=1` and `inst_ready=1`, throughput is one instruction per cycle after fill.
- No combinational path from `inst_ready`, `rsp_*` or `redirect_*` to `req_*` or `inst_*`.

## Structure
- Package `ifu_pkg`:
  - `INST_W=32`, `NOP=32'h00000013`
  - typedef `fetch_entry_t {pc, inst, err}`, parametrised via WIDTH localparam in the user
- Sub-module `ifu_fifo`: synchronous FIFO with parameters `DEPTH` and payload width, plus a `flush` input and registered outputs.
- Top holds `fpc`, the request register, the counters and the redirect logic.

## Test plan
- Reset release, memory `req_ready=1`, 1-cycle responses of 0x00000013: requests go to 0x80000000, 0x80000004, … Instructions come out one per cycle with matching `inst_pc`, first `inst_valid` at cycle 2.
- `inst_ready=0`, DEPTH=4: exactly 4 requests are accepted, then `req_valid` stays 0. Raising `inst_ready` for one cycle lets exactly one new request issue.
- `req_ready=0` for 5 cycles: `req_addr` stays 0x80000000 and no second request appears.
- Two outstanding requests (0x80000008, 0x8000000C), then redirect to 0x80000102: both responses are dropped. The next `req_addr` is 0x80000100, and the next delivered `inst_pc` is 0x80000100.
- Redirect in the same cycle as a response and a pop: the response is dropped, the popped instruction counts as delivered, and the FIFO is empty the next cycle.
- Response with `rsp_err=1` at 0x80000004: delivered with `inst_err=1`, and the next request is 0x80000008 (continuing after the faulting one). Apply `rst` mid-stream: all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants for the instruction fetch unit
package ifu_pkg;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP = 32'h00000013;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: show-ahead FIFO with flush; outputs come only from registers
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic                   valid,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  // pointers and occupancy; flush empties the buffer without touching storage
  always_ff @(posedge clk)
    if (rst || flush) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(push);
      rp_q <= rp_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  // payload storage, never reset; the head is masked while empty
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= din;
  assign valid = cnt_q != '0;
  assign dout = valid ? mem_q[rp_q] : '0;
  assign cnt = cnt_q;
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: decoupled fetch with credit-limited prefetch buffer and redirect flush
module ifu_prefetch import ifu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h80000000,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [WIDTH-1:0]  req_addr,
  input  logic              rsp_valid,
  input  logic [INST_W-1:0] rsp_data,
  input  logic              rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [WIDTH-1:0]  inst_pc,
  output logic              inst_err,
  input  logic              redirect_valid,
  input  logic [WIDTH-1:0]  redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [WIDTH-1:0]  pc;
    logic [INST_W-1:0] inst;
    logic              err;
  } fetch_entry_t;
  logic [WIDTH-1:0] fpc_q, fpc_d, req_addr_q, req_addr_d, rsp_pc_q, rsp_pc_d, start_pc;
  logic req_valid_q, req_valid_d, stale_q, stale_d;
  logic [CW-1:0] live_q, live_d, drop_q, drop_d, live_n, drop_n, cnt, cnt_n;
  logic [CW+1:0] used;
  logic acc, keep, hit, push, pop, issue;
  fetch_entry_t ent, head;
  // handshake accounting, credit check and next request; rsp_pc tracks the oldest live response
  always_comb begin
    acc = req_valid_q & req_ready;
    keep = req_valid_q & ~req_ready;
    hit = rsp_valid & (drop_q == '0);
    push = hit & ~redirect_valid;
    pop = inst_valid & inst_ready;
    live_n = live_q + CW'(acc & ~stale_q) - CW'(hit);
    drop_n = drop_q + CW'(acc & stale_q) - CW'(rsp_valid & ~hit);
    live_d = redirect_valid ? '0 : live_n;
    drop_d = redirect_valid ? live_n + drop_n : drop_n;
    cnt_n = redirect_valid ? '0 : cnt + CW'(push) - CW'(pop);
    used = (CW+2)'(cnt_n) + (CW+2)'(live_d) + (CW+2)'(drop_d);
    issue = ~keep & (used < (CW+2)'(DEPTH));
    start_pc = redirect_valid ? (redirect_pc & ~WIDTH'(3)) : fpc_q;
    fpc_d = issue ? start_pc + WIDTH'(4) : start_pc;
    req_valid_d = issue | keep;
    req_addr_d = issue ? start_pc : req_addr_q;
    stale_d = keep & (stale_q | redirect_valid);
    rsp_pc_d = redirect_valid ? start_pc : rsp_pc_q + (push ? WIDTH'(4) : '0);
    ent = '{pc: rsp_pc_q, inst: rsp_data, err: rsp_err};
  end
  // fetch state registers
  always_ff @(posedge clk)
    if (rst) begin
      fpc_q <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      stale_q <= 1'b0;
      live_q <= '0;
      drop_q <= '0;
    end else begin
      fpc_q <= fpc_d;
      req_valid_q <= req_valid_d;
      req_addr_q <= req_addr_d;
      rsp_pc_q <= rsp_pc_d;
      stale_q <= stale_d;
      live_q <= live_d;
      drop_q <= drop_d;
    end
  // a response with nothing outstanding means the memory side broke protocol
  always_ff @(posedge clk)
    if (!rst && rsp_valid) assert (live_q != '0 || drop_q != '0);
  ifu_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .din   (ent),
    .pop   (pop),
    .valid (inst_valid),
    .dout  (head),
    .cnt   (cnt)
  );
  assign req_valid = req_valid_q;
  assign req_addr = req_addr_q;
  assign inst = head.inst;
  assign inst_pc = head.pc;
  assign inst_err = head.err;
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: scoreboard bench with memory model and instruction-stream reference
module tb_ifu_prefetch;
  import ifu_pkg::*;
  localparam logic [31:0] RPC = 32'h80000000;
  logic clk = 0, rst = 1, req_ready = 0, rsp_valid = 0, rsp_err = 0, inst_ready = 0, redirect_valid = 0;
  logic [31:0] rsp_data = 0, redirect_pc = 0;
  logic req_valid, inst_valid, inst_err;
  logic [31:0] req_addr, inst, inst_pc;
  int total = 0, bad = 0;
  logic [31:0] mem_q[$], exp_q[$];
  logic [31:0] next_req = RPC, prev_addr = 0, last_pop_pc = 0, seed = 0;
  logic stale = 0, prev_pend = 0, saw_err4 = 0;
  int n_acc = 0, n_pop = 0;
  int p_rr = 100, p_rsp = 100, p_ir = 100, p_rd = 0, budget = -1;

  ifu_prefetch #(.WIDTH(32), .RESET_PC(RPC), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hsh(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a < 32'h80000400) ? NOP : hsh(a);
  endfunction

  function automatic logic merr(input logic [31:0] a);
    logic [31:0] h;
    h = hsh(a);
    return (a == 32'h80000004) || (a >= 32'h80000400 && h[5:3] == 3'd0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // monitor: every cycle's handshakes against the stream model
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
      next_req = RPC;
      stale = 0;
      prev_pend = 0;
      n_acc = 0;
    end else begin
      if (prev_pend) begin
        check("req_hold_valid", req_valid, 1);
        check("req_hold_addr", req_addr, prev_addr);
      end
      if (inst_valid) begin
        check("head_expected", exp_q.size() != 0, 1);
        if (inst_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e);
          check("inst", inst, mdata(e));
          check("inst_err", inst_err, merr(e));
          n_pop++;
          last_pop_pc = inst_pc;
          if (inst_pc == 32'h80000004 && inst_err) saw_err4 = 1;
        end
      end
      if (req_valid && req_ready) begin
        mem_q.push_back(req_addr);
        n_acc++;
        if (stale) stale = 0;
        else begin
          check("req_addr", req_addr, next_req);
          next_req += 4;
          if (!redirect_valid) exp_q.push_back(req_addr);
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        next_req = redirect_pc & ~32'd3;
        stale = req_valid && !req_ready;
      end
      prev_pend = req_valid && !req_ready;
      prev_addr = req_addr;
    end
  end

  task automatic tick();
    logic [31:0] a;
    @(posedge clk);
    #1;
    req_ready = $urandom_range(99) < p_rr;
    inst_ready = $urandom_range(99) < p_ir;
    redirect_valid = $urandom_range(99) < p_rd;
    redirect_pc = 32'h80000400 + $urandom_range(4095);
    rsp_valid = 0;
    rsp_data = 0;
    rsp_err = 0;
    if (mem_q.size() != 0 && budget != 0 && $urandom_range(99) < p_rsp) begin
      a = mem_q.pop_front();
      rsp_valid = 1;
      rsp_data = mdata(a);
      rsp_err = merr(a);
      if (budget > 0) budget--;
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1;
    tick();
    check("rst_req_valid", req_valid, 0);
    check("rst_req_addr", req_addr, RPC);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst_err", inst_err, 0);
    tick();
    rst = 0;
  endtask

  task automatic wait_pop();
    int n0;
    n0 = n_pop;
    for (int k = 0; k < 50 && n_pop == n0; k++) tick();
    check("pop_seen", n_pop != n0, 1);
  endtask

  initial begin
    int n0;
    logic found;
    seed = $urandom;
    do_reset();
    tick();
    check("first_req_valid", req_valid, 1);
    check("first_req_addr", req_addr, RPC);
    repeat (6) tick();
    n0 = n_pop;
    repeat (16) tick();
    check("throughput", n_pop - n0, 16);
    check("err_at_4", saw_err4, 1);
    do_reset();
    p_ir = 0;
    do_reset();
    repeat (15) tick();
    check("credit_acc", n_acc, 4);
    check("credit_idle", req_valid, 0);
    tick();
    inst_ready = 1;
    repeat (10) tick();
    check("credit_one_more", n_acc, 5);
    p_rr = 0;
    p_ir = 100;
    do_reset();
    tick();
    repeat (5) begin
      tick();
      check("stall_valid", req_valid, 1);
      check("stall_addr", req_addr, RPC);
    end
    check("stall_acc", n_acc, 0);
    p_rr = 100;
    p_ir = 0;
    budget = 0;
    do_reset();
    repeat (10) tick();
    check("redir_setup_acc", n_acc, 4);
    budget = 2;
    repeat (4) tick();
    check("pre_redir_valid", inst_valid, 1);
    check("pre_redir_pc", inst_pc, RPC);
    tick();
    redirect_valid = 1;
    redirect_pc = 32'h80000102;
    budget = -1;
    p_ir = 100;
    tick();
    check("redir_req_valid", req_valid, 1);
    check("redir_req_addr", req_addr, 32'h80000100);
    wait_pop();
    check("redir_first_pc", last_pop_pc, 32'h80000100);
    do_reset();
    repeat (8) tick();
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      tick();
      if (rsp_valid && inst_valid && inst_ready) begin
        found = 1;
        redirect_valid = 1;
        redirect_pc = 32'h80000200;
      end
    end
    check("collide_found", found, 1);
    tick();
    check("collide_empty", inst_valid, 0);
    wait_pop();
    check("collide_next_pc", last_pop_pc, 32'h80000200);
    p_rr = 70;
    p_rsp = 60;
    p_ir = 70;
    p_rd = 3;
    repeat (3000) tick();
    p_rr = 100;
    p_rsp = 100;
    p_ir = 100;
    p_rd = 0;
    repeat (20) tick();
    n0 = n_pop;
    repeat (10) tick();
    check("drain_flow", n_pop - n0, 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
